alu_uart_sequencer: RTL and testbench

Front-end sequencer for the ALU datapath in the UART build: consumes received bytes from the UART receiver, loads operand A, operand B and the opcode into registers that drive the ALU, captures the ALU result and flags, and returns them as two bytes through the UART transmitter. It sits between the UART RX/TX pair and the combinational ALU and owns all sequencing; the ALU stays purely combinational.

---
 rtl/alu_uart_sequencer_pkg.sv | 37 +++
 rtl/alu_uart_sequencer.sv | 98 +++++++++
 tb/tb_alu_uart_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/alu_uart_sequencer_pkg.sv
// rtl/alu_uart_sequencer_pkg.sv - shared widths, opcodes, flag bits and state encodings
package alu_uart_sequencer_pkg;

    localparam int BUS_DAT = 8;
    localparam int BUS_OP  = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_CARRY   = 1;
    localparam int FLAG_ILLEGAL = 2;

    typedef enum logic [2:0] {
        WAIT_A     = 3'd0,
        WAIT_B     = 3'd1,
        WAIT_OP    = 3'd2,
        EXEC       = 3'd3,
        WAIT_RES   = 3'd4,
        WAIT_FLAGS = 3'd5
    } state_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: op_is_legal = 1'b1;
            default:                        op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_uart_sequencer.sv
// rtl/alu_uart_sequencer.sv - loads ALU operands/opcode from UART bytes, returns result and flags
module alu_uart_sequencer
    import alu_uart_sequencer_pkg::*;
#(
    parameter int b_dat = BUS_DAT,
    parameter int b_op  = BUS_OP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_done,
    input  logic [7:0]       rx_data,
    input  logic             tx_done,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [b_dat-1:0] alu_a,
    output logic [b_dat-1:0] alu_b,
    output logic [b_op-1:0]  alu_op,
    input  logic [b_dat-1:0] alu_rdo,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             busy
);

    state_t     state;
    logic       illegal;
    logic [7:0] flags;
    logic [7:0] flags_next;

    always_comb begin
        flags_next               = 8'h00;
        flags_next[FLAG_ZERO]    = alu_zero;
        flags_next[FLAG_CARRY]   = alu_carry;
        flags_next[FLAG_ILLEGAL] = illegal;
    end

    // tx_data doubles as the captured result register until the flags byte replaces it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WAIT_A;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            tx_data  <= 8'h00;
            flags    <= 8'h00;
            illegal  <= 1'b0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (rx_done) begin
                        alu_a <= rx_data;
                        state <= WAIT_B;
                        busy  <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (rx_done) begin
                        alu_b <= rx_data;
                        state <= WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (rx_done) begin
                        alu_op  <= rx_data[b_op-1:0];
                        illegal <= (rx_data[7:b_op] != '0) || !op_is_legal(rx_data[b_op-1:0]);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    flags    <= flags_next;
                    tx_data  <= alu_rdo;
                    tx_start <= 1'b1;
                    state    <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (tx_done) begin
                        tx_data  <= flags;
                        tx_start <= 1'b1;
                        state    <= WAIT_FLAGS;
                    end
                end
                WAIT_FLAGS: begin
                    if (tx_done) begin
                        state <= WAIT_A;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= WAIT_A;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// tb/tb_alu_uart_sequencer.sv - directed bench with a small behavioural ALU on the operand outputs
module tb_alu_uart_sequencer;
    import alu_uart_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] alu_a, alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_rdo;
    logic       alu_carry, alu_zero;
    logic       busy;
    logic [8:0] wide;

    int checks = 0;
    int failures = 0;

    alu_uart_sequencer dut (
        .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
        .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rdo(alu_rdo),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Carry on SUB is the borrow out; undefined opcodes return zero.
    always_comb begin
        wide = 9'h000;
        case (alu_op)
            OP_ADD:  wide = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  wide = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  wide = {1'b0, alu_a & alu_b};
            OP_OR:   wide = {1'b0, alu_a | alu_b};
            OP_XOR:  wide = {1'b0, alu_a ^ alu_b};
            OP_SRA:  wide = {1'b0, 8'($signed(alu_a) >>> alu_b)};
            OP_SRL:  wide = {1'b0, alu_a >> alu_b};
            OP_NOR:  wide = {1'b0, ~(alu_a | alu_b)};
            default: wide = 9'h000;
        endcase
        alu_rdo   = wide[7:0];
        alu_carry = wide[8];
        alu_zero  = (wide[7:0] == 8'h00);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp_res,
                           input logic [7:0] exp_flags, input bit drop);
        send_byte(a);
        chk({tag, "_a"}, alu_a, a);
        chk({tag, "_busy"}, busy, 1);
        send_byte(b);
        send_byte(op);
        chk({tag, "_exec_nostart"}, tx_start, 0);
        tick();
        chk({tag, "_res_start"}, tx_start, 1);
        chk({tag, "_res"}, tx_data, exp_res);
        tick();
        chk({tag, "_res_pulse1"}, tx_start, 0);
        if (drop) begin
            send_byte(8'hAA);
            chk({tag, "_drop_a"}, alu_a, a);
            chk({tag, "_drop_hold"}, tx_data, exp_res);
        end
        tick();
        pulse_tx_done();
        chk({tag, "_flg_start"}, tx_start, 1);
        chk({tag, "_flg"}, tx_data, exp_flags);
        tick();
        chk({tag, "_flg_pulse1"}, tx_start, 0);
        pulse_tx_done();
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_idle_nostart"}, tx_start, 0);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_tx_data", tx_data, 0);
        reset = 1'b0;
        tick();

        run_txn("add", 8'hFF, 8'h01, 8'h20, 8'h00, 8'h03, 0);
        run_txn("sub_pos", 8'h05, 8'h03, 8'h22, 8'h02, 8'h00, 0);
        run_txn("sub_neg", 8'h03, 8'h05, 8'h22, 8'hFE, 8'h02, 0);
        run_txn("srl", 8'h80, 8'h03, 8'h02, 8'h10, 8'h00, 0);
        run_txn("nor", 8'h0F, 8'hF0, 8'h27, 8'h00, 8'h01, 0);
        run_txn("ill_3f", 8'h12, 8'h34, 8'h3F, 8'h00, 8'h05, 0);
        run_txn("ill_e0", 8'h00, 8'h00, 8'hE0, 8'h00, 8'h05, 0);
        run_txn("drop", 8'h0C, 8'h0A, 8'h24, 8'h08, 8'h00, 1);
        run_txn("after_drop", 8'h0C, 8'h0A, 8'h26, 8'h06, 8'h00, 0);

        // Reset in WAIT_B must clear the partial operand without waiting for a clock edge.
        send_byte(8'h5A);
        chk("wb_loaded", alu_a, 8'h5A);
        #2 reset = 1'b1;
        #1;
        chk("wb_rst_alu_a", alu_a, 0);
        chk("wb_rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("wb_rst_nostart", tx_start, 0);
        run_txn("post_rst_b", 8'h01, 8'h02, 8'h25, 8'h03, 8'h00, 0);

        // Reset in WAIT_FLAGS after the flags byte went out.
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h20);
        tick();
        tick();
        pulse_tx_done();
        chk("wf_flags", tx_data, 8'h03);
        #2 reset = 1'b1;
        #1;
        chk("wf_rst_tx_data", tx_data, 0);
        chk("wf_rst_tx_start", tx_start, 0);
        chk("wf_rst_alu_b", alu_b, 0);
        tick();
        reset = 1'b0;
        pulse_tx_done();
        chk("wf_no_start", tx_start, 0);
        chk("wf_idle", busy, 0);
        tick();
        chk("wf_no_start2", tx_start, 0);
        run_txn("post_rst_f", 8'h80, 8'h01, 8'h03, 8'hC0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
